mac_pipe: RTL
=============

// Module: mac_pipe
// PURPOSE
//  Parametrised 3-stage pipelined multiply-add/accumulate unit, successor to the fixed-width A*B+C pipe.
//  Adds valid/ready flow control, signed/unsigned operands, a per-beat FMA/accumulate mode and saturation.
//  Sits between an operand source (filter taps, dot-product feeder) and a result consumer.
// PARAMETERS
//  SIZE      8  operand width of A, B, C
//  GUARD     8  extra accumulator bits above 2*SIZE; RES_W = 2*SIZE+GUARD
//  SIGNED    0  1: A, B, C and result are two's complement; 0: unsigned
//  SATURATE  1  1: accumulate overflow clamps to max/min; 0: wraps modulo 2^RES_W
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       beat on A/B/C/mode/last is valid
//  in_ready   out  1       unit accepts a beat this cycle
//  A, B       in   SIZE    multiplicands
//  C          in   SIZE    addend (FMA mode only; ignored in ACC mode)
//  mode       in   1       0 = FMA (A*B+C), 1 = ACC (acc += A*B)
//  last       in   1       ACC mode: final beat of a sum; acc clears after it
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  data_out   out  RES_W   result
//  ovf        out  1       result of this beat saturated/wrapped (qualified by out_valid)
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, data_out, ovf, accumulator = 0. Reset mid-operation
//    discards all in-flight beats and any partial sum; no result is emitted for them.
//  - advance = !out_valid || out_ready; in_ready = advance. Whole pipe moves only on advance
//    (global stall); a beat is accepted when in_valid && in_ready.
//  - S1: register A, B, C, mode, last, valid. S2: P = A*B (2*SIZE, signed per SIGNED); C delayed.
//  - S3 FMA: data_out = P + ext(C) (sign/zero-extended to RES_W); never overflows; ovf=0; acc untouched.
//  - S3 ACC: sum = acc + ext(P); data_out = sum (clamped if SATURATE and overflow); acc <= data_out,
//    or acc <= 0 if last. Every ACC beat emits its running sum.
//  - Overflow: unsigned carry-out of RES_W, or signed operands equal-sign & result-sign differs.
//    SATURATE=1: clamp to all-ones (unsigned) / max or min signed; SATURATE=0: wrap. ovf=1 either way.
//  - Latency: 3 accepted cycles with out_ready held high; throughput 1 beat/cycle.
//  - Stall: while out_valid && !out_ready, data_out, ovf, out_valid and acc hold; no input accepted.
//  - FMA beats interleaved within an ACC sequence leave acc unchanged.
//  - Bubbles (in_valid=0) propagate as valid=0 and never update acc.
//  - Back-to-back last beats: each produces acc_prev+P then clears; next ACC beat starts from 0.
// STRUCTURE
//  - Package mac_pipe_pkg: size default, GUARD default, RES_W function, typedef mode_t
//    {MODE_FMA=1'b0, MODE_ACC=1'b1}, sat_max/sat_min constant functions.
//  - Sub-module mac_sat_add: combinational RES_W adder with SIGNED/SATURATE params,
//    outputs sum and ovf; used in S3 for both modes.
//  - Pipeline regs and handshake in mac_pipe; no other sub-modules.
// TESTING
//  1 SIZE=8 unsigned, out_ready=1: FMA A=200,B=100,C=55 -> 3 cycles later data_out=20055, ovf=0.
//  2 ACC: beats (3,4),(5,6),(7,8,last) -> outputs 12, 42, 98; next ACC (1,1) -> 1 (acc cleared).
//  3 SIGNED=1, GUARD=0, SATURATE=1: ACC (-128,-128) x2 -> 16384, then 32767 with ovf=1;
//    SATURATE=0 same stimulus -> second result -32768, ovf=1.
//  4 Backpressure: stream 6 FMA beats, drop out_ready for 4 cycles mid-stream -> in_ready=0 while
//    out_valid stalled, data_out held, all 6 results delivered in order, none lost/duplicated.
//  5 Reset asserted with 2 ACC beats in flight (acc=50) -> out_valid=0, acc=0 immediately;
//    after release ACC (2,2,last) -> 4.
//  6 Interleave ACC(2,3), FMA(1,1,C=9), ACC(4,5,last) -> 6, 10, 26; bubbles between beats change nothing.

Source files
------------

// File: rtl/mac_pipe_pkg.sv
// mac_pipe_pkg: shared widths, mode encoding and saturation limits
// for the pipelined multiply-add/accumulate unit.
package mac_pipe_pkg;

    localparam int SIZE_DEF  = 8;
    localparam int GUARD_DEF = 8;
    localparam int LIM_W     = 64;

    typedef enum logic {
        MODE_FMA = 1'b0,
        MODE_ACC = 1'b1
    } mode_t;

    typedef logic [LIM_W-1:0] lim_t;

    function automatic int res_w(input int size, input int guard);
        return 2 * size + guard;
    endfunction

    function automatic lim_t sat_max(input int w, input int sgn);
        lim_t ones;
        ones = '1;
        return (sgn != 0) ? ones >> (LIM_W - w + 1)
                          : ones >> (LIM_W - w);
    endfunction

    function automatic lim_t sat_min(input int w, input int sgn);
        lim_t one;
        one = lim_t'(1);
        return (sgn != 0) ? one << (w - 1) : '0;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational W-bit adder with overflow detect and
// optional clamping, signed or unsigned.
module mac_sat_add
    import mac_pipe_pkg::*;
#(
    parameter int W        = 24,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    localparam logic [W-1:0] MAXV = W'(sat_max(W, SIGNED));
    localparam logic [W-1:0] MINV = W'(sat_min(W, SIGNED));

    logic [W:0] w_raw;
    logic       w_ovf;
    logic       w_hi;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};

    always_comb begin
        w_ovf = 1'b0;
        w_hi  = 1'b1;
        if (SIGNED != 0) begin
            w_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
            // equal-sign overflow direction follows the operand sign
            w_hi  = !i_a[W-1];
        end else begin
            w_ovf = w_raw[W];
        end
        o_sum = w_raw[W-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            o_sum = w_hi ? MAXV : MINV;
        end
        o_ovf = w_ovf;
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: 3-stage multiply-add / accumulate pipe with valid/ready
// flow control, global stall on output backpressure.
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter  int SIZE     = SIZE_DEF,
    parameter  int GUARD    = GUARD_DEF,
    parameter  int SIGNED   = 0,
    parameter  int SATURATE = 1,
    localparam int RES_W    = res_w(SIZE, GUARD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  A,
    input  logic [SIZE-1:0]  B,
    input  logic [SIZE-1:0]  C,
    input  logic             mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] data_out,
    output logic             ovf
);

    localparam int PW = 2 * SIZE;

    logic             r_s1_v;
    logic [SIZE-1:0]  r_s1_a;
    logic [SIZE-1:0]  r_s1_b;
    logic [SIZE-1:0]  r_s1_c;
    mode_t            r_s1_mode;
    logic             r_s1_last;

    logic             r_s2_v;
    logic [PW-1:0]    r_s2_p;
    logic [SIZE-1:0]  r_s2_c;
    mode_t            r_s2_mode;
    logic             r_s2_last;

    logic             r_out_v;
    logic [RES_W-1:0] r_data;
    logic             r_ovf;
    logic [RES_W-1:0] r_acc;

    logic             w_advance;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [RES_W-1:0] w_p_ext;
    logic [RES_W-1:0] w_c_ext;
    logic [RES_W-1:0] w_add_a;
    logic [RES_W-1:0] w_sum;
    logic             w_ovf;

    assign w_advance = !r_out_v || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_v;
    assign data_out  = r_data;
    assign ovf       = r_ovf;

    // extending to 2*SIZE first keeps the truncated product exact
    always_comb begin
        if (SIGNED != 0) begin
            w_a_ext = {{SIZE{r_s1_a[SIZE-1]}}, r_s1_a};
            w_b_ext = {{SIZE{r_s1_b[SIZE-1]}}, r_s1_b};
        end else begin
            w_a_ext = {{SIZE{1'b0}}, r_s1_a};
            w_b_ext = {{SIZE{1'b0}}, r_s1_b};
        end
        w_prod = w_a_ext * w_b_ext;
    end

    always_comb begin
        if (SIGNED != 0) begin
            w_p_ext = RES_W'($signed(r_s2_p));
            w_c_ext = RES_W'($signed(r_s2_c));
        end else begin
            w_p_ext = RES_W'(r_s2_p);
            w_c_ext = RES_W'(r_s2_c);
        end
        w_add_a = (r_s2_mode == MODE_ACC) ? r_acc : w_c_ext;
    end

    mac_sat_add #(
        .W        (RES_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .i_a   (w_add_a),
        .i_b   (w_p_ext),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_c    <= '0;
            r_s1_mode <= MODE_FMA;
            r_s1_last <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_p    <= '0;
            r_s2_c    <= '0;
            r_s2_mode <= MODE_FMA;
            r_s2_last <= 1'b0;
            r_out_v   <= 1'b0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
            r_acc     <= '0;
        end else if (w_advance) begin
            r_s1_v    <= in_valid;
            r_s1_a    <= A;
            r_s1_b    <= B;
            r_s1_c    <= C;
            r_s1_mode <= mode_t'(mode);
            r_s1_last <= last;
            r_s2_v    <= r_s1_v;
            r_s2_p    <= w_prod;
            r_s2_c    <= r_s1_c;
            r_s2_mode <= r_s1_mode;
            r_s2_last <= r_s1_last;
            r_out_v   <= r_s2_v;
            if (r_s2_v) begin
                r_data <= w_sum;
                r_ovf  <= w_ovf;
                if (r_s2_mode == MODE_ACC) begin
                    r_acc <= r_s2_last ? '0 : w_sum;
                end
            end
        end
    end

endmodule
